// File: rtl/calc_ratio_scaled.sv
// Scaled-ratio divider: result = (numerator * SCALE) / denominator, one quotient bit per clock.
// Optional macro CALC_RATIO_ROUND_EN selects round-to-nearest instead of truncation.
module calc_ratio_scaled #(
    parameter int unsigned NUM_W = 16,
    parameter int unsigned DEN_W = 16,
    parameter int unsigned SCALE = 100,
    parameter int unsigned OUT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NUM_W-1:0] numerator,
    input  logic [DEN_W-1:0] denominator,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] result,
    output logic             div_zero,
    output logic             overflow
);

    localparam int unsigned SC_W  = $clog2(SCALE + 1);
    localparam int unsigned DVD_W = NUM_W + SC_W + 1;
    localparam int unsigned CNT_W = $clog2(DVD_W);
    localparam int unsigned REM_W = DEN_W + 1;
    localparam int unsigned SH_W  = DEN_W + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FINISH
    } state_t;

    state_t             r_state;
    logic [DVD_W-1:0]   r_dvd;
    logic [DEN_W-1:0]   r_den;
    logic [REM_W-1:0]   r_rem;
    logic [DVD_W-1:0]   r_q;
    logic [CNT_W-1:0]   r_cnt;

    logic [DVD_W-1:0]   w_dvd_init;
    logic [SH_W-1:0]    w_rem_sh;
    logic               w_fits;
    logic [REM_W-1:0]   w_rem_nx;
    logic               w_q_ovf;

    // Dividend is formed at full width so the rounding term can never wrap.
`ifdef CALC_RATIO_ROUND_EN
    assign w_dvd_init = DVD_W'(numerator) * DVD_W'(SCALE) + DVD_W'(denominator >> 1);
`else
    assign w_dvd_init = DVD_W'(numerator) * DVD_W'(SCALE);
`endif

    // Restoring step: shift in next dividend bit, subtract when it fits.
    assign w_rem_sh = {r_rem, r_dvd[r_cnt]};
    assign w_fits   = (w_rem_sh >= SH_W'(r_den));
    assign w_rem_nx = w_fits ? REM_W'(w_rem_sh - SH_W'(r_den)) : REM_W'(w_rem_sh);
    assign w_q_ovf  = |r_q[DVD_W-1:OUT_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_dvd    <= '0;
            r_den    <= '0;
            r_rem    <= '0;
            r_q      <= '0;
            r_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            div_zero <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dvd <= w_dvd_init;
                        r_den <= denominator;
                        r_rem <= '0;
                        r_q   <= '0;
                        r_cnt <= CNT_W'(DVD_W - 1);
                        busy  <= 1'b1;
                        r_state <= (denominator == '0) ? S_FINISH : S_CALC;
                    end
                end
                S_CALC: begin
                    r_rem        <= w_rem_nx;
                    r_q[r_cnt]   <= w_fits;
                    if (r_cnt == '0) begin
                        r_state <= S_FINISH;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_FINISH: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                    if (r_den == '0) begin
                        result   <= '1;
                        div_zero <= 1'b1;
                        overflow <= 1'b0;
                    end else if (w_q_ovf) begin
                        result   <= '1;
                        div_zero <= 1'b0;
                        overflow <= 1'b1;
                    end else begin
                        result   <= r_q[OUT_W-1:0];
                        div_zero <= 1'b0;
                        overflow <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_ratio_scaled.sv
// Self-checking bench for calc_ratio_scaled: directed corner cases plus random operands
// compared against an arithmetic reference model.
module tb_calc_ratio_scaled;

    localparam int unsigned NUM_W = 16;
    localparam int unsigned DEN_W = 16;
    localparam int unsigned SCALE = 100;
    localparam int unsigned OUT_W = 8;
    localparam int          LAT_NORMAL = 25;
`ifdef CALC_RATIO_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             start;
    logic [NUM_W-1:0] numerator;
    logic [DEN_W-1:0] denominator;
    logic             busy;
    logic             done;
    logic [OUT_W-1:0] result;
    logic             div_zero;
    logic             overflow;

    int n_cmp = 0;
    int n_mis = 0;

    calc_ratio_scaled #(
        .NUM_W(NUM_W),
        .DEN_W(DEN_W),
        .SCALE(SCALE),
        .OUT_W(OUT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .numerator  (numerator),
        .denominator(denominator),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .div_zero   (div_zero),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the scaled ratio.
    function automatic void model(input int unsigned n, input int unsigned d,
                                  output int unsigned r, output bit dz, output bit ov,
                                  output int lat);
        longint unsigned q;
        if (d == 0) begin
            r = (1 << OUT_W) - 1; dz = 1'b1; ov = 1'b0; lat = 1;
        end else begin
            q = (longint'(n) * SCALE + (ROUND ? longint'(d / 2) : 0)) / d;
            lat = LAT_NORMAL;
            dz  = 1'b0;
            if (q > (1 << OUT_W) - 1) begin
                r = (1 << OUT_W) - 1; ov = 1'b1;
            end else begin
                r = int'(q); ov = 1'b0;
            end
        end
    endfunction

    // Issue one op, optionally injecting an ignored start mid-flight, and check it.
    task automatic do_op(input int unsigned n, input int unsigned d, input string tag,
                         input bit no_wait, input bit chk_pulse, input int inj);
        int unsigned er;
        bit edz, eov;
        int elat, edges;
        bit found;
        model(n, d, er, edz, eov, elat);
        if (!no_wait) @(negedge clk);
        start = 1'b1;
        numerator = NUM_W'(n);
        denominator = DEN_W'(d);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({tag, ".busy"}, 32'(busy), 32'd1);
        edges = 0;
        found = 1'b0;
        while (!found && edges < 60) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (done) begin
                found = 1'b1;
            end else if (inj > 0 && edges == inj) begin
                start = 1'b1;
                numerator = NUM_W'(9);
                denominator = DEN_W'(0);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({tag, ".done_seen"}, 32'(found), 32'd1);
        check({tag, ".latency"}, 32'(edges), 32'(elat));
        check({tag, ".result"}, 32'(result), er);
        check({tag, ".div_zero"}, 32'(div_zero), 32'(edz));
        check({tag, ".overflow"}, 32'(overflow), 32'(eov));
        check({tag, ".busy_off"}, 32'(busy), 32'd0);
        if (chk_pulse) begin
            @(negedge clk);
            check({tag, ".pulse"}, 32'(done), 32'd0);
            check({tag, ".held"}, 32'(result), er);
        end
    endtask

    initial begin
        int dones;
        int unsigned rn, rd;
        reset = 1'b1;
        start = 1'b0;
        numerator = '0;
        denominator = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.result", 32'(result), 32'd0);
        check("rst.div_zero", 32'(div_zero), 32'd0);
        check("rst.overflow", 32'(overflow), 32'd0);
        reset = 1'b0;

        do_op(50, 200, "pct25", 1'b0, 1'b1, 0);
        do_op(2, 3, "two_thirds", 1'b0, 1'b1, 0);
        do_op(1, 3, "one_third", 1'b0, 1'b1, 0);
        do_op(7, 0, "div0", 1'b0, 1'b1, 0);
        do_op(300, 100, "ovf", 1'b0, 1'b1, 0);
        do_op(10, 100, "after_ovf", 1'b0, 1'b1, 0);
        do_op(0, 5, "num_zero", 1'b0, 1'b1, 0);
        do_op(123, 456, "mid_start", 1'b0, 1'b1, 5);
        // Start in the done cycle must be accepted immediately.
        do_op(50, 200, "b2b_a", 1'b0, 1'b0, 0);
        do_op(2, 3, "b2b_b", 1'b1, 1'b1, 0);

        // Abort in CALC: outputs cleared, no done pulse afterwards.
        @(negedge clk);
        start = 1'b1;
        numerator = NUM_W'(123);
        denominator = DEN_W'(45);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.result", 32'(result), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        check("abort.flags", {30'd0, div_zero, overflow}, 32'd0);
        dones = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort.no_done", 32'(dones), 32'd0);
        do_op(123, 45, "post_abort", 1'b0, 1'b1, 0);

        for (int i = 0; i < 20; i++) begin
            rn = (i % 4 == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 600);
            if (i % 7 == 3) rd = 0;
            else if (i % 2 == 1) rd = $urandom_range(1, 400);
            else rd = $urandom_range(1, 65535);
            do_op(rn, rd, $sformatf("rand%0d", i), (i % 3 == 2), 1'b0, 0);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
